// File: rtl/chip8_timers_pkg.sv
// Shared constants and types for the CHIP-8 delay/sound timer block.
// The platform clock rate comes from the CHIP8_CLOCK_HZ define and
// falls back to 50 MHz when no platform value is given.

`ifndef CHIP8_CLOCK_HZ
`define CHIP8_CLOCK_HZ 50_000_000
`endif

package chip8_timers_pkg;

  localparam int   TIMER_W           = 8;
  localparam logic WR_SEL_DT         = 1'b0;
  localparam logic WR_SEL_ST         = 1'b1;
  localparam int   PLATFORM_CLOCK_HZ = `CHIP8_CLOCK_HZ;

  typedef enum logic {
    SILENT = 1'b0,
    TONE   = 1'b1
  } tone_state_e;

  // Terminal count of the half-period counter. The counter runs from this value
  // down to 0, so one half-period lasts half_period()+1 clocks.
  function automatic int half_period(input int clock_hz, input int tone_hz);
    return (clock_hz / (2 * tone_hz)) - 1;
  endfunction

endpackage

// File: rtl/chip8_timers_if.sv
// CPU-facing bus of the timer block.
// It carries the load strobe, the load target and the load data,
// plus the timer values and status flags that the block returns.

interface chip8_timers_if;
  import chip8_timers_pkg::*;

  logic               wr_en;
  logic               wr_sel;
  logic [TIMER_W-1:0] wr_data;
  logic [TIMER_W-1:0] dt_value;
  logic [TIMER_W-1:0] st_value;
  logic               dt_zero;
  logic               sound_active;
  logic               speaker;

  modport master (
    output wr_en, wr_sel, wr_data,
    input  dt_value, st_value, dt_zero, sound_active, speaker
  );

  modport slave (
    input  wr_en, wr_sel, wr_data,
    output dt_value, st_value, dt_zero, sound_active, speaker
  );

endinterface

// File: rtl/chip8_timers_tone_gen.sv
// Square-wave buzzer generator for the sound timer.
// While enable is high, the speaker toggles every HALF+1 clocks.
// Each burst starts with a full low half-period.
// This module is only built when CHIP8_BUZZER_TONE_EN is defined.

module chip8_tone_gen
  import chip8_timers_pkg::*;
#(
  parameter int CLOCK_HZ = PLATFORM_CLOCK_HZ,
  parameter int TONE_HZ  = 440
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic speaker
);

  localparam int HALF  = half_period(CLOCK_HZ, TONE_HZ);
  localparam int CNT_W = (HALF > 0) ? $clog2(HALF + 1) : 1;
  localparam logic [CNT_W-1:0] HALF_V  = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  tone_state_e      state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             spk_r, spk_s;

  // Next-state, counter and speaker logic; SILENT parks the counter at HALF.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    spk_s   = spk_r;
    case (state_r)
      SILENT: begin
        spk_s = 1'b0;
        cnt_s = HALF_V;
        if (enable) begin
          state_s = TONE;
        end else begin
          state_s = SILENT;
        end
      end
      TONE: begin
        if (!enable) begin
          state_s = SILENT;
          spk_s   = 1'b0;
          cnt_s   = HALF_V;
        end else if (cnt_r == '0) begin
          spk_s = ~spk_r;
          cnt_s = HALF_V;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s = SILENT;
        spk_s   = 1'b0;
        cnt_s   = HALF_V;
      end
    endcase
  end

  // State, counter and registered speaker drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= SILENT;
      cnt_r   <= HALF_V;
      spk_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      spk_r   <= spk_s;
    end
  end

  assign speaker = spk_r;

endmodule

// File: rtl/chip8_timers.sv
// CHIP-8 delay timer (DT) and sound timer (ST).
// Both timers count down once on each rising edge of the 60 Hz tick.
// A CPU load takes priority over a decrement of the same timer.
// With CHIP8_BUZZER_TONE_EN defined, the speaker carries a TONE_HZ square wave.
// Without it, the speaker output follows sound_active to drive an active buzzer.

module chip8_timers
  import chip8_timers_pkg::*;
#(
  parameter int CLOCK_HZ = PLATFORM_CLOCK_HZ,
  parameter int TONE_HZ  = 440
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick_60hz,
  chip8_timers_if.slave  bus
);

  if (CLOCK_HZ < (2 * TONE_HZ)) begin : g_param_check
    $error("chip8_timers: CLOCK_HZ must be at least twice TONE_HZ");
  end

  logic [TIMER_W-1:0] dt_r, dt_s;
  logic [TIMER_W-1:0] st_r, st_s;
  logic               tick_q_r;
  logic               tick_edge_s;
  logic               sound_active_s;
  logic               speaker_s;

  assign tick_edge_s = tick_60hz & ~tick_q_r;

  // Next timer values: a load wins over a tick, and a tick never wraps below 0.
  always_comb begin
    dt_s = dt_r;
    st_s = st_r;
    if (bus.wr_en && (bus.wr_sel == WR_SEL_DT)) begin
      dt_s = bus.wr_data;
    end else if (tick_edge_s && (dt_r != '0)) begin
      dt_s = dt_r - TIMER_W'(1);
    end else begin
      dt_s = dt_r;
    end
    if (bus.wr_en && (bus.wr_sel == WR_SEL_ST)) begin
      st_s = bus.wr_data;
    end else if (tick_edge_s && (st_r != '0)) begin
      st_s = st_r - TIMER_W'(1);
    end else begin
      st_s = st_r;
    end
  end

  // Timer registers and the tick edge-detect flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      dt_r     <= '0;
      st_r     <= '0;
      tick_q_r <= 1'b0;
    end else begin
      dt_r     <= dt_s;
      st_r     <= st_s;
      tick_q_r <= tick_60hz;
    end
  end

  assign sound_active_s = (st_r != '0);

`ifdef CHIP8_BUZZER_TONE_EN
  chip8_tone_gen #(
    .CLOCK_HZ (CLOCK_HZ),
    .TONE_HZ  (TONE_HZ)
  ) u_tone_gen (
    .clk     (clk),
    .reset   (reset),
    .enable  (sound_active_s),
    .speaker (speaker_s)
  );
`else
  assign speaker_s = sound_active_s;
`endif

  assign bus.dt_value     = dt_r;
  assign bus.st_value     = st_r;
  assign bus.dt_zero      = (dt_r == '0);
  assign bus.sound_active = sound_active_s;
  assign bus.speaker      = speaker_s;

endmodule

// File: tb/tb_chip8_timers.sv
// Self-checking bench for chip8_timers.
// It drives a fixed vector table, a few multi-cycle corner sequences and a
// randomized run, and checks every output against a reference model.
// The reference model works on plain integers.

module tb_chip8_timers;

  localparam int HALF_LEN = 1000 / (2 * 100);

  logic clk = 1'b0;
  logic reset;
  logic tick;

  always #5 clk = ~clk;

  chip8_timers_if bus();

  chip8_timers #(
    .CLOCK_HZ (1000),
    .TONE_HZ  (100)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick_60hz (tick),
    .bus       (bus)
  );

  typedef struct {
    bit       rst;
    bit       tck;
    bit       we;
    bit       sel;
    bit [7:0] data;
    int       exp_dt;
    int       exp_st;
  } vec_t;

  int tests_run    = 0;
  int tests_failed = 0;

  int m_dt, m_st, m_n;
  bit m_tick_q, m_in_tone, m_spk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clock(input bit r, input bit t, input bit we, input bit sel, input int d);
    bit old_act;
    bit edge_seen;
    old_act   = (m_st != 0);
    edge_seen = t && !m_tick_q;
    if (r) begin
      m_dt = 0; m_st = 0; m_tick_q = 0; m_in_tone = 0; m_spk = 0; m_n = 0;
    end else begin
      if (we && !sel) m_dt = d;
      else if (edge_seen && m_dt > 0) m_dt = m_dt - 1;
      if (we && sel) m_st = d;
      else if (edge_seen && m_st > 0) m_st = m_st - 1;
      m_tick_q = t;
      if (!m_in_tone) begin
        if (old_act) begin
          m_in_tone = 1; m_n = 0;
        end
        m_spk = 0;
      end else if (!old_act) begin
        m_in_tone = 0; m_spk = 0;
      end else begin
        m_n = m_n + 1;
        m_spk = ((m_n / HALF_LEN) % 2) == 1;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model and compare all outputs.
  task automatic step(input bit r, input bit t, input bit we, input bit sel, input bit [7:0] d);
    bit exp_spk;
    reset = r; tick = t; bus.wr_en = we; bus.wr_sel = sel; bus.wr_data = d;
    @(posedge clk);
    model_clock(r, t, we, sel, int'(d));
    #1;
`ifdef CHIP8_BUZZER_TONE_EN
    exp_spk = m_spk;
`else
    exp_spk = (m_st != 0);
`endif
    check("dt_value", bus.dt_value, m_dt);
    check("st_value", bus.st_value, m_st);
    check("dt_zero", bus.dt_zero, (m_dt == 0));
    check("sound_active", bus.sound_active, (m_st != 0));
    check("speaker", bus.speaker, exp_spk);
    @(negedge clk);
  endtask

  vec_t tbl[23];

  initial begin
    reset = 1'b1; tick = 1'b0;
    bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_data = 8'h00;
    m_dt = 0; m_st = 0; m_n = 0; m_tick_q = 0; m_in_tone = 0; m_spk = 0;

    tbl = '{
      '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00,  0,    0},
      '{1'b0, 1'b0, 1'b1, 1'b0, 8'h03,  3,    0},
      '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00,  2,    0},
      '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00,  2,    0},
      '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00,  1,    0},
      '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00,  1,    0},
      '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00,  0,    0},
      '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00,  0,    0},
      '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00,  0,    0},
      '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00,  0,    0},
      '{1'b0, 1'b0, 1'b1, 1'b0, 8'd10, 10,    0},
      '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00,  9,    0},
      '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00,  9,    0},
      '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00,  9,    0},
      '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00,  9,    0},
      '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00,  9,    0},
      '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00,  9,    0},
      '{1'b0, 1'b0, 1'b1, 1'b0, 8'h05,  5,    0},
      '{1'b0, 1'b0, 1'b1, 1'b1, 8'h07,  5,    7},
      '{1'b0, 1'b1, 1'b1, 1'b0, 8'h20,  32,   6},
      '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00,  32,   6},
      '{1'b0, 1'b1, 1'b1, 1'b1, 8'h33,  31,  51},
      '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00,  31,  51}
    };

    @(negedge clk);

    // Table-driven vectors: hand-computed expectations plus the model check.
    for (int i = 0; i < 23; i++) begin
      step(tbl[i].rst, tbl[i].tck, tbl[i].we, tbl[i].sel, tbl[i].data);
      check($sformatf("tbl%0d_dt", i), bus.dt_value, tbl[i].exp_dt);
      check($sformatf("tbl%0d_st", i), bus.st_value, tbl[i].exp_st);
      check($sformatf("tbl%0d_dt_zero", i), bus.dt_zero, (tbl[i].exp_dt == 0));
    end

    // Reset in the middle of a sound burst, with a load and a tick also asserted.
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h80);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h80);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h55);
    check("rst_dt", bus.dt_value, 0);
    check("rst_st", bus.st_value, 0);
    check("rst_dt_zero", bus.dt_zero, 1);
    check("rst_sound", bus.sound_active, 0);
    check("rst_speaker", bus.speaker, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

`ifdef CHIP8_BUZZER_TONE_EN
    // Tone build: five low cycles after entering TONE, then a toggle every five cycles.
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h02);
    check("burst_start_low", bus.speaker, 0);
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      check($sformatf("burst_k%0d", k), bus.speaker, (k >= 6 && k <= 10));
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("burst_st_zero", bus.st_value, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("burst_end_low", bus.speaker, 0);
`else
    // Level build: speaker follows ST != 0 until the tick edge that clears ST.
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h01);
    check("lvl_on", bus.speaker, 1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      check($sformatf("lvl_hold%0d", k), bus.speaker, 1);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("lvl_off", bus.speaker, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
`endif

    // Randomized run checked against the model.
    for (int n = 0; n < 800; n++) begin
      bit r, t, we, sel;
      bit [7:0] d;
      r   = ($urandom_range(99) == 0);
      t   = ($urandom_range(3) == 0);
      we  = ($urandom_range(9) == 0);
      sel = $urandom_range(1);
      d   = ($urandom_range(3) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(12));
      step(r, t, we, sel, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/chip8_timers.md
CHIP8_TIMERS -- requirements
Module: chip8_timers

Interface
REQ-001 SHALL have parameter CLOCK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter TONE_HZ, default 440, buzzer square-wave frequency in Hz.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port tick_60hz  input  1  60 Hz tick from the clock-divider timer block; nominally a one-cycle pulse.
REQ-006 SHALL have port wr_en  input  1  CPU load strobe, one cycle per load.
REQ-007 SHALL have port wr_sel  input  1  load target: 0 = delay timer (DT), 1 = sound timer (ST).
REQ-008 SHALL have port wr_data  input  8  value to load.
REQ-009 SHALL have port dt_value  output  8  current DT, registered; read by Fx07.
REQ-010 SHALL have port st_value  output  8  current ST, registered.
REQ-011 SHALL have port dt_zero  output  1  high when DT == 0.
REQ-012 SHALL have port sound_active  output  1  high when ST != 0.
REQ-013 SHALL have port speaker  output  1  buzzer drive.

Function
REQ-014 SHALL register tick_60hz once and detect its rising edge; a tick held high for N cycles SHALL count as one tick.
REQ-015 SHALL decrement each non-zero timer by exactly 1 on each detected tick edge.
REQ-016 SHALL hold a timer at 0 on a tick; no wrap to 0xFF.
REQ-017 SHALL load wr_data into the selected timer on the clock edge where wr_en is high; the new value is visible on dt_value/st_value the next cycle.
REQ-018 SHALL give the load priority when a load and a tick edge hit the same timer in the same cycle; that timer takes wr_data and is not decremented.
REQ-019 SHALL still decrement the unselected timer on a tick edge when a load and the tick edge coincide.
REQ-020 SHALL derive dt_zero and sound_active combinationally from the registered timer values, with no extra latency.
REQ-021 SHALL implement the tone generator as a two-state FSM: SILENT and TONE.
REQ-022 SHALL move SILENT -> TONE when sound_active rises and TONE -> SILENT when it falls.
REQ-023 SHALL, in TONE, count a half-period counter from HALF = CLOCK_HZ/(2*TONE_HZ) - 1 down to 0, toggle speaker at 0, and reload HALF.
REQ-024 SHALL, in SILENT, drive speaker 0 and hold the counter at HALF, so every tone burst starts with a full low half-period.
REQ-025 SHALL apply a load of 0 to ST while in TONE immediately; the FSM enters SILENT the next cycle.

Reset
REQ-026 SHALL, on reset, clear DT and ST to 0, clear the tick edge register, put the FSM in SILENT, load the counter with HALF, and drive speaker 0.
REQ-027 SHALL give reset priority over wr_en and tick_60hz.
REQ-028 SHALL, on reset asserted mid-burst, drive speaker low on the next cycle.

Configuration
REQ-029 SHALL, with macro CHIP8_BUZZER_TONE_EN defined, build the FSM/counter and drive speaker with the TONE_HZ square wave.
REQ-030 SHALL, without CHIP8_BUZZER_TONE_EN, omit the FSM and counter and drive speaker = sound_active (level drive for an active buzzer); all other behaviour is unchanged.

Structure
REQ-031 SHALL take the shared constants from the chip8 package: TIMER_W = 8, WR_SEL_DT = 0, WR_SEL_ST = 1.
REQ-032 SHALL take CLOCK_HZ defaults from the platform clock-speed define.
REQ-033 SHALL implement the tone FSM and counter in sub-module chip8_tone_gen (inputs clk, reset, enable; output speaker), instantiated only under CHIP8_BUZZER_TONE_EN.

Verification
REQ-034 SHALL cover: load DT = 3, then 4 tick pulses -> dt_value 2, 1, 0, 0; dt_zero high only after the third tick.
REQ-035 SHALL cover: tick_60hz held high for 5 cycles with DT = 10 -> DT = 9, a single decrement.
REQ-036 SHALL cover: DT = 5, then wr_en, wr_sel = 0, wr_data = 0x20 in the same cycle as a tick edge, with ST = 7 -> DT = 0x20, ST = 6.
REQ-037 SHALL cover: with CLOCK_HZ = 1000 and TONE_HZ = 100, load ST = 2 -> speaker low for 5 cycles, then toggles every 5 cycles; low and SILENT the cycle after ST reaches 0.
REQ-038 SHALL cover: reset asserted during TONE with DT = ST = 0x80 -> next cycle all outputs 0, dt_zero = 1, speaker = 0.
REQ-039 SHALL cover: build without CHIP8_BUZZER_TONE_EN, load ST = 1 -> speaker high until the next tick edge, then low.
